mem_arbiter: RTL

- Shares the single main-memory block port between the instruction-cache controller (IF stage) and the data-cache controller (MEM stage).
- Resolves simultaneous cache misses with round-robin priority and sequences each memory transaction through a fixed FSM.
- Routes memory read data and busywait back to the granted cache and stalls the other cache.
- Sits between both cache controllers and main memory. Both caches use the existing block-level busywait protocol unchanged.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/rr_arb2.sv | 20 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I-cache/D-cache main-memory arbiter.
// Holds the state encoding, the owner encoding and the default widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 28;
    localparam int BLOCK_W_DEF = 128;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam logic OWNER_ICACHE = 1'b0;
    localparam logic OWNER_DCACHE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on a tie the requester that did not
// own the port last time wins; a lone requester always wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner
);

    always_comb begin
        winner = OWNER_ICACHE;
        if (req == 2'b11) begin
            winner = ~last_owner;
        end else if (req == 2'b10) begin
            winner = OWNER_DCACHE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory block port between the I-cache and D-cache
// controllers; each transaction runs IDLE -> ISSUE -> WAIT -> RELEASE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int BLOCK_W        = BLOCK_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               icache_mem_read,
    input  logic [ADDR_W-1:0]  icache_mem_address,
    output logic [BLOCK_W-1:0] icache_mem_readdata,
    output logic               icache_mem_busywait,
    input  logic               dcache_mem_read,
    input  logic               dcache_mem_write,
    input  logic [ADDR_W-1:0]  dcache_mem_address,
    input  logic [BLOCK_W-1:0] dcache_mem_writedata,
    output logic [BLOCK_W-1:0] dcache_mem_readdata,
    output logic               dcache_mem_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait,
    output logic               grant_owner,
    output logic               mem_timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e         state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic               terr_q, terr_d;

    logic icache_req, dcache_req, winner, complete;

    assign icache_req = icache_mem_read;
    assign dcache_req = dcache_mem_read | dcache_mem_write;

    // ISSUE deliberately ignores mem_busywait so a stale low level is never taken as done.
    assign complete = (state_q == WAIT) && !mem_busywait;

    rr_arb2 u_rr_arb2 (
        .req        ({dcache_req, icache_req}),
        .last_owner (last_q),
        .winner     (winner)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tcnt_d  = tcnt_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                if (icache_req || dcache_req) begin
                    owner_d = winner;
                    last_d  = winner;
                    state_d = ISSUE;
                    if (winner == OWNER_DCACHE) begin
                        // Read+write together is a write-back that must go first.
                        addr_d  = dcache_mem_address;
                        wdata_d = dcache_mem_writedata;
                        wr_d    = dcache_mem_write;
                        rd_d    = ~dcache_mem_write;
                    end else begin
                        addr_d  = icache_mem_address;
                        wdata_d = '0;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (complete) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    tcnt_d  = '0;
                    state_d = RELEASE;
                end else begin
                    if (tcnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                    if (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        terr_d = 1'b1;
                    end
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            owner_q <= OWNER_ICACHE;
            last_q  <= OWNER_ICACHE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tcnt_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tcnt_q  <= tcnt_d;
            terr_q  <= terr_d;
        end
    end

    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_address     = addr_q;
    assign mem_writedata   = wdata_q;
    assign grant_owner     = owner_q;
    assign mem_timeout_err = terr_q;

    assign icache_mem_busywait = icache_req & ~(complete && owner_q == OWNER_ICACHE);
    assign dcache_mem_busywait = dcache_req & ~(complete && owner_q == OWNER_DCACHE);
    assign icache_mem_readdata = (complete && owner_q == OWNER_ICACHE) ? mem_readdata : '0;
    assign dcache_mem_readdata = (complete && owner_q == OWNER_DCACHE) ? mem_readdata : '0;

endmodule
